clk_rst_gen: RTL and testbench

CLK_RST_GEN -- requirements
Module: clk_rst_gen

---
 rtl/clk_rst_gen.sv | 90 +++++++++
 tb/tb_clk_rst_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/clk_rst_gen.sv
// clk_rst_gen: divided clock, clock-enable and held reset generator; CLKGEN_RUNTIME_DIV_EN enables runtime ratio loads
module clk_rst_gen #(
  parameter int DIV_DEFAULT = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int RST_HOLD    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 sys_rst_i,
  input  logic [CNT_WIDTH-1:0] div_i,
  input  logic                 div_load,
  output logic                 div_ack,
  output logic                 clk_o,
  output logic                 clk_en_o,
  output logic                 rst_o,
  output logic                 rst_n_o,
  output logic                 ready_o
);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {S_RESET, S_HOLD, S_RUN} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_cnt, r_ratio, r_pend;
  logic                   r_pend_vld;
  logic [HW-1:0]          r_hold;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt, w_ratio_nxt, w_ld_val;
  logic                   w_ld, w_run, w_run_nxt, w_bnd, w_apply;
`ifdef CLKGEN_RUNTIME_DIV_EN
  assign w_ld     = div_load;
  assign w_ld_val = (div_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : div_i;
`else
  logic w_unused;
  assign w_unused = ^{div_i, div_load};
  assign w_ld     = 1'b0;
  assign w_ld_val = CNT_WIDTH'(DIV_DEFAULT);
`endif
  assign w_run       = r_state != S_RESET;
  assign w_run_nxt   = w_run || !r_sync[SYNC_STAGES-1];
  assign w_bnd       = w_run && (r_cnt == r_ratio - 1'b1);
  assign w_apply     = w_bnd && (w_ld || r_pend_vld);
  assign w_ratio_nxt = w_apply ? (w_ld ? w_ld_val : r_pend) : r_ratio;
  assign w_cnt_nxt   = (w_run && !w_bnd) ? r_cnt + 1'b1 : '0;
  // reset-release synchronizer: set asynchronously, drains zeros on clk
  always_ff @(posedge clk or posedge sys_rst_i)
    if (sys_rst_i) r_sync <= '1;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
  // period counter, ratio update at boundaries, registered clock/enable outputs decoded from next count
  always_ff @(posedge clk or posedge sys_rst_i)
    if (sys_rst_i) begin
      r_cnt      <= '0;
      r_ratio    <= CNT_WIDTH'(DIV_DEFAULT);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      clk_o      <= 1'b0;
      clk_en_o   <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_ratio    <= w_ratio_nxt;
      r_pend     <= (w_ld && !w_bnd) ? w_ld_val : r_pend;
      r_pend_vld <= !w_bnd && (w_ld || r_pend_vld);
      clk_o      <= w_run_nxt && (w_cnt_nxt < (w_ratio_nxt >> 1));
      clk_en_o   <= w_run_nxt && (w_cnt_nxt == w_ratio_nxt - 1'b1);
      div_ack    <= w_apply;
    end
  // RESET -> HOLD on synchronized release, HOLD -> RUN after RST_HOLD enable pulses
  always_ff @(posedge clk or posedge sys_rst_i)
    if (sys_rst_i) begin
      r_state <= S_RESET;
      r_hold  <= '0;
      rst_o   <= 1'b1;
      rst_n_o <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: r_state <= r_sync[SYNC_STAGES-1] ? S_RESET : S_HOLD;
        S_HOLD: if (clk_en_o) begin
          r_hold <= (r_hold == HW'(RST_HOLD)) ? r_hold : r_hold + 1'b1;
          if (r_hold == HW'(RST_HOLD - 1)) begin
            r_state <= S_RUN;
            rst_o   <= 1'b0;
            rst_n_o <= 1'b1;
            ready_o <= 1'b1;
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_RESET;
      endcase
    end
endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: directed checks of divider, enable, reset hold sequence and ratio loads
module tb_clk_rst_gen;
  logic clk = 1'b0, rst = 1'b1, div_load = 1'b0;
  logic [15:0] div_i = '0;
  logic a_ack, a_clk, a_en, a_rst, a_rstn, a_rdy;
  logic b_ack, b_clk, b_en, b_rst, b_rstn, b_rdy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  clk_rst_gen #(.DIV_DEFAULT(2), .CNT_WIDTH(16), .RST_HOLD(4), .SYNC_STAGES(2)) u_a (
    .clk(clk), .sys_rst_i(rst), .div_i(div_i), .div_load(div_load), .div_ack(a_ack),
    .clk_o(a_clk), .clk_en_o(a_en), .rst_o(a_rst), .rst_n_o(a_rstn), .ready_o(a_rdy));
  clk_rst_gen #(.DIV_DEFAULT(5), .CNT_WIDTH(16), .RST_HOLD(4), .SYNC_STAGES(2)) u_b (
    .clk(clk), .sys_rst_i(rst), .div_i(div_i), .div_load(div_load), .div_ack(b_ack),
    .clk_o(b_clk), .clk_en_o(b_en), .rst_o(b_rst), .rst_n_o(b_rstn), .ready_o(b_rdy));
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " a_clk"}, a_clk, 1'b0);
    chk({tag, " a_en"}, a_en, 1'b0);
    chk({tag, " a_ack"}, a_ack, 1'b0);
    chk({tag, " a_rst"}, a_rst, 1'b1);
    chk({tag, " a_rstn"}, a_rstn, 1'b0);
    chk({tag, " a_rdy"}, a_rdy, 1'b0);
    chk({tag, " b_clk"}, b_clk, 1'b0);
    chk({tag, " b_en"}, b_en, 1'b0);
    chk({tag, " b_rst"}, b_rst, 1'b1);
    chk({tag, " b_rdy"}, b_rdy, 1'b0);
  endtask
  // k counts clk edges after sys_rst_i falls; HOLD begins after edge 3 with cnt = 0
  task automatic release_seq(input int n);
    for (int k = 1; k <= n; k++) begin
      tick;
      chk($sformatf("a_clk k=%0d", k), a_clk, k >= 3 && (k - 3) % 2 == 0);
      chk($sformatf("a_en k=%0d", k), a_en, k >= 4 && (k - 3) % 2 == 1);
      chk($sformatf("a_rst k=%0d", k), a_rst, k < 11);
      chk($sformatf("a_rstn k=%0d", k), a_rstn, k >= 11);
      chk($sformatf("a_rdy k=%0d", k), a_rdy, k >= 11);
      chk($sformatf("b_clk k=%0d", k), b_clk, k >= 3 && (k - 3) % 5 < 2);
      chk($sformatf("b_en k=%0d", k), b_en, k >= 3 && (k - 3) % 5 == 4);
      chk($sformatf("b_rst k=%0d", k), b_rst, k < 23);
      chk($sformatf("b_rdy k=%0d", k), b_rdy, k >= 23);
    end
  endtask
  task automatic wait_en;
    int n = 0;
    while (a_en !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("wait_en", a_en, 1'b1);
  endtask
  task automatic chk_a(input string tag, input logic c, input logic e, input logic k);
    chk({tag, " clk"}, a_clk, c);
    chk({tag, " en"}, a_en, e);
    chk({tag, " ack"}, a_ack, k);
  endtask
  initial begin
    tick;
    tick;
    chk_reset_outputs("por");
    rst = 1'b0;
    release_seq(25);
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk_reset_outputs("run_rst");
    tick;
    rst = 1'b0;
    release_seq(5);
    rst = 1'b1;
    #1;
    chk_reset_outputs("hold_rst");
    tick;
    rst = 1'b0;
    release_seq(25);
    wait_en;
`ifdef CLKGEN_RUNTIME_DIV_EN
    div_i = 16'd4;
    div_load = 1'b1;
    tick;
    div_load = 1'b0;
    chk_a("r4 c0", 1'b1, 1'b0, 1'b1);
    tick;
    chk_a("r4 c1", 1'b1, 1'b0, 1'b0);
    div_i = 16'd3;
    div_load = 1'b1;
    tick;
    chk_a("r4 c2", 1'b0, 1'b0, 1'b0);
    div_i = 16'd6;
    tick;
    div_load = 1'b0;
    chk_a("r4 c3", 1'b0, 1'b1, 1'b0);
    tick;
    chk_a("r6 c0", 1'b1, 1'b0, 1'b1);
    for (int j = 1; j < 6; j++) begin
      tick;
      chk_a($sformatf("r6 c%0d", j), j < 3, j == 5, 1'b0);
    end
    div_i = 16'd0;
    div_load = 1'b1;
    tick;
    div_load = 1'b0;
    chk_a("r0 c0", 1'b1, 1'b0, 1'b1);
    tick;
    chk_a("r0 c1", 1'b0, 1'b1, 1'b0);
    div_i = 16'd1;
    div_load = 1'b1;
    tick;
    div_load = 1'b0;
    chk_a("r1 c0", 1'b1, 1'b0, 1'b1);
    tick;
    chk_a("r1 c1", 1'b0, 1'b1, 1'b0);
`else
    div_i = 16'd5;
    div_load = 1'b1;
    tick;
    div_load = 1'b0;
    chk_a("fixed c0", 1'b1, 1'b0, 1'b0);
    tick;
    chk_a("fixed c1", 1'b0, 1'b1, 1'b0);
    tick;
    chk_a("fixed c2", 1'b1, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
